// File: rtl/pm_fetch_ctrl.sv
// Program-memory fetch controller wrapped around the next-PC select mux.
// Issues one fixed-latency read at a time and presents the result to the decoder over valid/ready.
module pm_fetch_ctrl #(
  parameter int              AW        = 4,
  parameter int              IW        = 8,
  parameter int              MEM_LAT   = 1,
  parameter logic [AW-1:0]   RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [AW-1:0] pm_addr,
  output logic          pm_rd,
  input  logic [IW-1:0] pm_rdata,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_inc,
  output logic [1:0]    pc_sel,
  input  logic [AW-1:0] pc_next,
  input  logic          branch_req,
  input  logic          irq_req,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);

  // lat_cnt only ever holds 0..MEM_LAT-1
  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_IRQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] lat_cnt_q, lat_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VEC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    lat_cnt_d  = lat_cnt_q;
    pm_rd      = 1'b0;
    pc_sel     = SEL_INC;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        pm_rd     = 1'b1;
        lat_cnt_d = LAT_LOAD;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          instr_d    = pm_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        // Redirect requests only matter in the acceptance cycle; irq wins over branch.
        if (instr_ready) begin
          if (irq_req)         pc_sel = SEL_IRQ;
          else if (branch_req) pc_sel = SEL_BR;
          else                 pc_sel = SEL_INC;
          pc_d    = pc_next;
          valid_d = 1'b0;
          state_d = run ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pm_addr     = pc_q;
  assign pc          = pc_q;
  assign pc_inc      = pc_q + AW'(1);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

  a_sel_reserved: assert property (@(posedge clk) disable iff (!rst_n) pc_sel != 2'b11);
  a_one_in_flight: assert property (@(posedge clk) disable iff (!rst_n) pm_rd |-> !valid_q);

endmodule

// File: tb/tb_pm_fetch_ctrl.sv
// Bench for pm_fetch_ctrl: scoreboard of expected fetches/instructions checked by a negedge monitor,
// plus a MEM_LAT=3 instance exercising reset in the middle of a read.
module tb_pm_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int t0 = 0;
  int t3 = 0;
  logic mon_en = 1'b0;

  // ---------------- main instance, MEM_LAT = 1 ----------------
  logic       rst_n, run, pm_rd, branch_req, irq_req, instr_valid, instr_ready;
  logic [3:0] pm_addr, pc, pc_inc, pc_next, instr_pc, br_tgt, irq_vec;
  logic [1:0] pc_sel;
  logic [7:0] pm_rdata, instr;

  assign pc_next = (pc_sel == 2'b00) ? pc_inc :
                   (pc_sel == 2'b01) ? br_tgt :
                   (pc_sel == 2'b10) ? irq_vec : 4'h0;

  logic       m1_vld = 1'b0;
  logic [3:0] m1_addr = 4'h0;
  always_ff @(posedge clk) begin
    m1_vld  <= pm_rd;
    m1_addr <= pm_addr;
  end
  assign pm_rdata = m1_vld ? {m1_addr, ~m1_addr} : 8'hEE;

  pm_fetch_ctrl #(.AW(4), .IW(8), .MEM_LAT(1), .RESET_VEC(4'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pm_addr(pm_addr), .pm_rd(pm_rd),
    .pm_rdata(pm_rdata), .pc(pc), .pc_inc(pc_inc), .pc_sel(pc_sel), .pc_next(pc_next),
    .branch_req(branch_req), .irq_req(irq_req), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  // ---------------- second instance, MEM_LAT = 3, RESET_VEC = A ----------------
  logic       rst3_n, run3, pm_rd3, br3, irq3, instr_valid3, instr_ready3;
  logic [3:0] pm_addr3, pc3, pc_inc3, pc_next3, instr_pc3;
  logic [1:0] pc_sel3;
  logic [7:0] pm_rdata3, instr3;

  assign pc_next3 = (pc_sel3 == 2'b00) ? pc_inc3 : 4'h0;

  logic [2:0] m3_vld = 3'b000;
  logic [3:0] m3_addr [3];
  always_ff @(posedge clk) begin
    m3_vld     <= {m3_vld[1:0], pm_rd3};
    m3_addr[0] <= pm_addr3;
    m3_addr[1] <= m3_addr[0];
    m3_addr[2] <= m3_addr[1];
  end
  assign pm_rdata3 = m3_vld[2] ? {m3_addr[2], ~m3_addr[2]} : 8'hEE;

  pm_fetch_ctrl #(.AW(4), .IW(8), .MEM_LAT(3), .RESET_VEC(4'hA)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .run(run3), .pm_addr(pm_addr3), .pm_rd(pm_rd3),
    .pm_rdata(pm_rdata3), .pc(pc3), .pc_inc(pc_inc3), .pc_sel(pc_sel3), .pc_next(pc_next3),
    .branch_req(br3), .irq_req(irq3), .instr(instr3), .instr_pc(instr_pc3),
    .instr_valid(instr_valid3), .instr_ready(instr_ready3)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0] addr;
    int         cyc;
  } fetch_t;

  typedef struct {
    logic [3:0] ipc;
    logic [7:0] ins;
    logic [1:0] sel;
    logic [3:0] inc;
  } instr_t;

  fetch_t fq[$];
  instr_t iq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_fetch(input logic [3:0] a, input int c);
    fetch_t f;
    f.addr = a;
    f.cyc  = c;
    fq.push_back(f);
  endtask

  task automatic expect_instr(input logic [3:0] a, input logic [1:0] sel);
    instr_t e;
    e.ipc = a;
    e.ins = {a, ~a};
    e.sel = sel;
    e.inc = a + 4'd1;
    iq.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT issues a fetch or hands over an instruction.
  initial begin
    logic       hs, prev_valid, prev_hs;
    logic [7:0] prev_instr;
    logic [3:0] prev_ipc, inc_m;
    fetch_t     f;
    instr_t     e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_instr = 8'h0;
    prev_ipc   = 4'h0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        hs    = instr_valid && instr_ready;
        inc_m = pc + 4'd1;
        chk("pc_inc", 32'(pc_inc), 32'(inc_m));
        if (pm_rd) begin
          chk("pm_rd_while_valid", 32'(instr_valid), 32'd0);
          if (fq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pm_rd: pm_addr=%0h with no fetch expected (t=%0t)", pm_addr, $time);
          end else begin
            f = fq.pop_front();
            chk("pm_addr", 32'(pm_addr), 32'(f.addr));
            if (f.cyc >= 0) chk("pm_rd_cycle", 32'(cyc - t0), 32'(f.cyc));
          end
        end
        if (hs) begin
          if (iq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_instr: instr=%0h instr_pc=%0h (t=%0t)", instr, instr_pc, $time);
          end else begin
            e = iq.pop_front();
            chk("instr", 32'(instr), 32'(e.ins));
            chk("instr_pc", 32'(instr_pc), 32'(e.ipc));
            chk("pc_sel_hs", 32'(pc_sel), 32'(e.sel));
            chk("pc_inc_hs", 32'(pc_inc), 32'(e.inc));
          end
        end else begin
          chk("pc_sel_idle", 32'(pc_sel), 32'd0);
        end
        if (prev_valid && !prev_hs) begin
          chk("hold_valid", 32'(instr_valid), 32'd1);
          chk("hold_instr", 32'(instr), 32'(prev_instr));
          chk("hold_instr_pc", 32'(instr_pc), 32'(prev_ipc));
        end
        prev_valid = instr_valid;
        prev_hs    = hs;
        prev_instr = instr;
        prev_ipc   = instr_pc;
      end
    end
  end

  task automatic wait_hs(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(instr_valid && instr_ready) && n < 40);
    if (!(instr_valid && instr_ready)) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no handshake within %0d cycles", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] a, input logic [1:0] sel, input logic br, input logic irq,
                      input logic [3:0] d1, input logic [3:0] d2, input string name);
    expect_instr(a, sel);
    branch_req = br;
    irq_req    = irq;
    br_tgt     = d1;
    irq_vec    = d2;
    wait_hs(name);
    branch_req = 1'b0;
    irq_req    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; run = 1'b0; instr_ready = 1'b1;
    branch_req = 1'b0; irq_req = 1'b0; br_tgt = 4'h0; irq_vec = 4'h0;
    rst3_n = 1'b0; run3 = 1'b0; instr_ready3 = 1'b1; br3 = 1'b0; irq3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pm_rd", 32'(pm_rd), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);

    // T1: sequential fetches, three-cycle cadence
    expect_fetch(4'h0, 1);
    rst_n  = 1'b1;
    run    = 1'b1;
    t0     = cyc;
    mon_en = 1'b1;
    step(4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, "t1a"); expect_fetch(4'h1, 4);
    step(4'h1, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, "t1b"); expect_fetch(4'h2, 7);
    step(4'h2, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, "t1c"); expect_fetch(4'h3, 10);
    // T2: branch to F, then wrap to 0 through pc+1
    step(4'h3, 2'b01, 1'b1, 1'b0, 4'hF, 4'h0, "t2a"); expect_fetch(4'hF, -1);
    step(4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, "t2b"); expect_fetch(4'h0, -1);
    // T3: branch, then irq beating a simultaneous branch
    step(4'h0, 2'b01, 1'b1, 1'b0, 4'h9, 4'h0, "t3a"); expect_fetch(4'h9, -1);
    step(4'h9, 2'b10, 1'b1, 1'b1, 4'h9, 4'h4, "t3b"); expect_fetch(4'h4, -1);

    // T4: decoder stalls 5 cycles in HOLD
    instr_ready = 1'b0;
    expect_instr(4'h4, 2'b00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 20);
    chk("t4_valid_seen", 32'(instr_valid), 32'd1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    wait_hs("t4");
    expect_fetch(4'h5, -1);

    // T5: run drops during WAIT; instruction still delivered, then idle
    expect_instr(4'h5, 2'b00);
    @(posedge clk);
    #1;
    run = 1'b0;
    wait_hs("t5");
    repeat (10) @(negedge clk);
    chk("t5_idle_valid", 32'(instr_valid), 32'd0);
    chk("t5_idle_pc", 32'(pc), 32'd6);

    // Restart from idle for a single fetch
    expect_fetch(4'h6, -1);
    expect_instr(4'h6, 2'b00);
    run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pm_rd && n < 20);
    chk("restart_pm_rd", 32'(pm_rd), 32'd1);
    @(posedge clk);
    #1;
    run = 1'b0;
    wait_hs("restart");
    repeat (4) @(negedge clk);
    chk("fq_empty", 32'(fq.size()), 32'd0);
    chk("iq_empty", 32'(iq.size()), 32'd0);

    // T6: MEM_LAT=3 instance, reset in WAIT abandons the read
    chk("t6_rst_pc", 32'(pc3), 32'hA);
    chk("t6_rst_valid", 32'(instr_valid3), 32'd0);
    chk("t6_rst_pm_rd", 32'(pm_rd3), 32'd0);
    @(posedge clk);
    #1;
    rst3_n = 1'b1;
    run3   = 1'b1;
    t3     = cyc;
    for (int r = 0; r <= 6; r++) begin
      @(negedge clk);
      chk($sformatf("t6_pm_rd_c%0d", r), 32'(pm_rd3), 32'((r == 1) || (r == 6)));
      chk($sformatf("t6_valid_c%0d", r), 32'(instr_valid3), 32'(r == 5));
      if (r == 5) begin
        chk("t6_instr", 32'(instr3), 32'hA5);
        chk("t6_instr_pc", 32'(instr_pc3), 32'hA);
        chk("t6_pc_sel", 32'(pc_sel3), 32'd0);
      end
      if (r == 6) begin
        chk("t6_pm_addr2", 32'(pm_addr3), 32'hB);
        chk("t6_pc2", 32'(pc3), 32'hB);
      end
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst3_n = 1'b0;
    @(posedge clk);
    #1;
    rst3_n = 1'b1;
    run3   = 1'b0;
    @(negedge clk);
    chk("t6_after_pc", 32'(pc3), 32'hA);
    chk("t6_after_pm_addr", 32'(pm_addr3), 32'hA);
    chk("t6_after_pm_rd", 32'(pm_rd3), 32'd0);
    chk("t6_after_instr", 32'(instr3), 32'd0);
    chk("t6_after_instr_pc", 32'(instr_pc3), 32'd0);
    chk("t6_after_valid", 32'(instr_valid3), 32'd0);
    chk("t6_after_pc_sel", 32'(pc_sel3), 32'd0);
    chk("t6_late_data_present", 32'(pm_rdata3), 32'hB4);
    repeat (3) begin
      @(negedge clk);
      chk("t6_late_valid", 32'(instr_valid3), 32'd0);
      chk("t6_late_instr", 32'(instr3), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
